// File: rtl/lifted_scan_pkg.sv
// Shared state encoding and counter sizing for the lifted-port scan driver.
// Optional parity feature (macro LIFTED_SCAN_PARITY_EN) lives in the top.
package lifted_scan_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SHIFT_IN  = 3'd1;
  localparam state_t ST_UPDATE    = 3'd2;
  localparam state_t ST_SETTLE    = 3'd3;
  localparam state_t ST_CAPTURE   = 3'd4;
  localparam state_t ST_SHIFT_OUT = 3'd5;

  // Headroom of two lets the count reach N+1 when a parity bit is appended.
  function automatic int cnt_w(input int n_in, input int n_out);
    int m;
    m = (n_in > n_out) ? n_in : n_out;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/lifted_scan_shreg.sv
// Shift register: serial-in at the MSB shifting right (LSB-first fill), or
// parallel load then shift right so q_o[0] is the serial-out bit.
module lifted_scan_shreg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q, data_d, shifted;

  if (W == 1) begin : g_one
    assign shifted = ser_i;
  end else begin : g_wide
    assign shifted = {ser_i, data_q[W-1:1]};
  end

  always_comb begin
    data_d = data_q;
    if (load_i)       data_d = load_data_i;
    else if (shift_i) data_d = shifted;
  end

  // NOTE: a plain register, so it takes the synchronous reset; a RAM-style array would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/lifted_port_scan_driver.sv
// Serially loads lifted inputs, applies them atomically, settles, captures the
// lifted outputs and streams them back. Optional parity: LIFTED_SCAN_PARITY_EN.
module lifted_port_scan_driver
  import lifted_scan_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             si_data,
  input  logic             si_valid,
  output logic             si_ready,
  output logic             so_data,
  output logic             so_valid,
  input  logic             so_ready,
  output logic [N_IN-1:0]  lifted_input,
  input  logic [N_OUT-1:0] lifted_output,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = cnt_w(N_IN, N_OUT);
`ifdef LIFTED_SCAN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam logic [CW-1:0] IN_LAST   = CW'(N_IN + PAR - 1);
  localparam logic [CW-1:0] OUT_LAST  = CW'(N_OUT + PAR - 1);
  localparam logic [CW-1:0] N_IN_C    = CW'(N_IN);
  localparam logic [CW-1:0] N_OUT_C   = CW'(N_OUT);
  localparam int            SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [N_IN-1:0] li_q, li_d;
  logic            done_q, done_d;
  logic [N_IN-1:0]  in_q;
  logic [N_OUT-1:0] cap_q;

  logic si_fire, so_fire, in_shift, out_shift, cap_load;
  assign si_ready  = (state_q == ST_IDLE) || (state_q == ST_SHIFT_IN);
  assign so_valid  = (state_q == ST_SHIFT_OUT);
  assign si_fire   = si_valid && si_ready;
  assign so_fire   = so_valid && so_ready;
  assign in_shift  = si_fire && (cnt_q < N_IN_C);
  assign out_shift = so_fire && (cnt_q < N_OUT_C);
  assign cap_load  = (state_q == ST_CAPTURE);

  lifted_scan_shreg #(.W(N_IN)) u_in_shreg (
    .clk(CLK), .rst(RESET), .load_i(1'b0), .load_data_i('0),
    .shift_i(in_shift), .ser_i(si_data), .q_o(in_q)
  );

  lifted_scan_shreg #(.W(N_OUT)) u_cap_shreg (
    .clk(CLK), .rst(RESET), .load_i(cap_load), .load_data_i(lifted_output),
    .shift_i(out_shift), .ser_i(1'b0), .q_o(cap_q)
  );

`ifdef LIFTED_SCAN_PARITY_EN
  logic par_q, par_d, err_q, err_d;
  assign so_data = (cnt_q == N_OUT_C) ? par_q : cap_q[0];
  assign err     = err_q;
`else
  assign so_data = cap_q[0];
  assign err     = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    li_d     = li_q;
    done_d   = 1'b0;
`ifdef LIFTED_SCAN_PARITY_EN
    par_d    = par_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_SHIFT_IN: begin
        if (si_fire) begin
          if (cnt_q == IN_LAST) begin
            cnt_d   = '0;
            state_d = ST_UPDATE;
`ifdef LIFTED_SCAN_PARITY_EN
            // Parity bit arrives after all data bits are already in in_q.
            if (si_data != ^in_q) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_SHIFT_IN;
          end
        end
      end
      ST_UPDATE: begin
        li_d = in_q;
        if (SETTLE > 0) begin
          settle_d = SETTLE_LD;
          state_d  = ST_SETTLE;
        end else begin
          state_d  = ST_CAPTURE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d  = ST_CAPTURE;
        else                settle_d = settle_q - 1'b1;
      end
      ST_CAPTURE: begin
        cnt_d   = '0;
        state_d = ST_SHIFT_OUT;
`ifdef LIFTED_SCAN_PARITY_EN
        par_d   = ^lifted_output;
`endif
      end
      ST_SHIFT_OUT: begin
        if (so_fire) begin
          if (cnt_q == OUT_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      li_q     <= '0;
      done_q   <= 1'b0;
`ifdef LIFTED_SCAN_PARITY_EN
      par_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      li_q     <= li_d;
      done_q   <= done_d;
`ifdef LIFTED_SCAN_PARITY_EN
      par_q    <= par_d;
      err_q    <= err_d;
`endif
    end
  end

  assign lifted_input = li_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_lifted_port_scan_driver.sv
// Bench for lifted_port_scan_driver (N_IN=2, N_OUT=1, SETTLE=1); the partial
// circuit is modelled as lifted_output = ~lifted_input[0].
module tb_lifted_port_scan_driver;

  localparam int N_IN  = 2;
  localparam int N_OUT = 1;

  logic             CLK, RESET;
  logic             si_data, si_valid, si_ready;
  logic             so_data, so_valid, so_ready;
  logic [N_IN-1:0]  lifted_input;
  logic [N_OUT-1:0] lifted_output;
  logic             busy, done, err;

  lifted_port_scan_driver #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
    .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
    .lifted_input(lifted_input), .lifted_output(lifted_output),
    .busy(busy), .done(done), .err(err)
  );

  assign lifted_output = ~lifted_input[0];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] din;     // din[k] is the k-th bit sent
    int         gap;     // idle si cycles before every bit
    int         stall;   // so_ready low cycles on the first output bit
    logic [1:0] exp_li;
  } vec_t;

  vec_t vecs[4];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      si_valid = 1'b0;
      @(negedge CLK);
      check("gap_si_ready", si_ready, 1);
    end
    si_valid = 1'b1;
    si_data  = b;
    t = 0;
    while (!si_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("si_ready_wait", si_ready, 1);
    @(negedge CLK);
    si_valid = 1'b0;
  endtask

  task automatic drain(input int stall, input logic [1:0] exp_li);
    int   lat;
    logic e;
    lat = 0;
    while (!so_valid && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    check("capture_latency", lat, 3);
    check("lifted_input", lifted_input, exp_li);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge CLK);
          check("stall_so_valid", so_valid, 1);
          check("stall_so_data", so_data, e);
          check("stall_no_done", done, 0);
        end
      end
      check("so_valid", so_valid, 1);
      check("so_data", so_data, e);
      so_ready = 1'b1;
      @(negedge CLK);
      so_ready = 1'b0;
      if (exp_q.size() == 0) begin
        check("done_pulse", done, 1);
        check("idle_after_done", busy, 0);
        check("si_ready_after_done", si_ready, 1);
      end else begin
        check("no_early_done", done, 0);
      end
    end
    @(negedge CLK);
    check("done_single_cycle", done, 0);
    check("err_quiet", err, 0);
  endtask

  task automatic run_txn(input vec_t v);
`ifdef LIFTED_SCAN_PARITY_EN
    exp_q.push_back(~v.din[0]);
    exp_q.push_back(~v.din[0]);
`else
    exp_q.push_back(~v.din[0]);
`endif
    for (int k = 0; k < N_IN; k++) send_bit(v.din[k], v.gap);
`ifdef LIFTED_SCAN_PARITY_EN
    send_bit(^v.din, v.gap);
`endif
    drain(v.stall, v.exp_li);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din: 2'b01, gap: 0, stall: 0, exp_li: 2'b01};
    vecs[1] = '{din: 2'b00, gap: 2, stall: 0, exp_li: 2'b00};
    vecs[2] = '{din: 2'b10, gap: 0, stall: 5, exp_li: 2'b10};
    vecs[3] = '{din: 2'b11, gap: 1, stall: 2, exp_li: 2'b11};

    RESET = 1'b1; si_data = 1'b0; si_valid = 1'b0; so_ready = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("rst_lifted_input", lifted_input, 2'b00);
    check("rst_so_valid", so_valid, 0);
    check("rst_si_ready", si_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Reset while settling aborts the transaction and clears the lifted inputs.
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
`ifdef LIFTED_SCAN_PARITY_EN
    send_bit(1'b0, 0);
`endif
    @(negedge CLK);
    check("settle_busy", busy, 1);
    check("settle_lifted_input", lifted_input, 2'b11);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_lifted_input", lifted_input, 2'b00);
    check("abort_busy", busy, 0);
    check("abort_so_valid", so_valid, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check("abort_no_done", done, 0);
      check("abort_stay_idle", busy, 0);
    end

`ifdef LIFTED_SCAN_PARITY_EN
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    check("parity_err_pulse", err, 1);
    check("parity_err_idle", busy, 0);
    check("parity_err_hold", lifted_input, 2'b00);
    @(negedge CLK);
    check("parity_err_single", err, 0);
    check("parity_err_hold2", lifted_input, 2'b00);
    run_txn('{din: 2'b01, gap: 0, stall: 0, exp_li: 2'b01});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
